// File: rtl/ex_muldiv_if.sv
// EX-side request/result bundle for the HI/LO multiply/divide unit.
interface ex_muldiv_if;
  logic        start;
  logic [3:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, rs_val, rt_val, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val, flush,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/ex_muldiv.sv
// HI/LO multiply/divide unit in EX: multi-cycle MULT/DIV, single-cycle MTHI/MTLO.
// Define MULDIV_MADD_EN to enable MADD/MADDU/MSUB/MSUBU (ops 6..9).
module ex_muldiv #(
  parameter int MUL_CYCLES = 4
) (
  input logic        clk,
  input logic        rst,
  ex_muldiv_if.slave bus
);

  localparam int DIV_CYCLES = 32;
  localparam logic [4:0] MUL_LD = 5'(MUL_CYCLES - 1);
  localparam logic [4:0] DIV_LD = 5'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [32:0] a_q, a_d;
  logic [32:0] b_q, b_d;
  logic [31:0] rem_q, rem_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic [1:0]  acc_q, acc_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        is_mul, is_mulu, is_div, is_divu;
  logic        is_mthi, is_mtlo;
  logic [1:0]  acc_op;

  always_comb begin
    is_mul  = 1'b0;
    is_mulu = 1'b0;
    is_div  = 1'b0;
    is_divu = 1'b0;
    is_mthi = 1'b0;
    is_mtlo = 1'b0;
    acc_op  = 2'd0;
    case (bus.op)
      4'd0: is_mul  = 1'b1;
      4'd1: is_mulu = 1'b1;
      4'd2: is_div  = 1'b1;
      4'd3: is_divu = 1'b1;
      4'd4: is_mthi = 1'b1;
      4'd5: is_mtlo = 1'b1;
`ifdef MULDIV_MADD_EN
      4'd6: begin is_mul  = 1'b1; acc_op = 2'd1; end
      4'd7: begin is_mulu = 1'b1; acc_op = 2'd1; end
      4'd8: begin is_mul  = 1'b1; acc_op = 2'd2; end
      4'd9: begin is_mulu = 1'b1; acc_op = 2'd2; end
`endif
      default: ;
    endcase
  end

  // 33x33 signed product; only the low 64 bits reach HI/LO
  logic [63:0] prod;
  logic [63:0] mul_res;
  assign prod = 64'($signed(a_q) * $signed(b_q));

  always_comb begin
    case (acc_q)
      2'd1:    mul_res = {hi_q, lo_q} + prod;
      2'd2:    mul_res = {hi_q, lo_q} - prod;
      default: mul_res = prod;
    endcase
  end

  // one restoring step: a_q[31:0] shifts dividend out, quotient in
  logic [32:0] rem_sh;
  logic        qbit;
  logic [31:0] rem_nx;
  logic [31:0] quo_nx;
  assign rem_sh = {rem_q, a_q[31]};
  assign qbit   = rem_sh >= {1'b0, b_q[31:0]};
  assign rem_nx = qbit ? (rem_sh[31:0] - b_q[31:0]) : rem_sh[31:0];
  assign quo_nx = {a_q[30:0], qbit};

  logic [31:0] rs_abs, rt_abs;
  logic        dz, sgn;
  assign rs_abs = bus.rs_val[31] ? -bus.rs_val : bus.rs_val;
  assign rt_abs = bus.rt_val[31] ? -bus.rt_val : bus.rt_val;
  assign dz     = bus.rt_val == 32'd0;
  assign sgn    = is_div & ~dz;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          if (is_mthi) hi_d = bus.rs_val;
          if (is_mtlo) lo_d = bus.rs_val;
          if (is_mul || is_mulu) begin
            a_d     = {is_mul & bus.rs_val[31], bus.rs_val};
            b_d     = {is_mul & bus.rt_val[31], bus.rt_val};
            acc_d   = acc_op;
            cnt_d   = MUL_LD;
            state_d = MUL;
          end
          if (is_div || is_divu) begin
            a_d     = {1'b0, (sgn & bus.rs_val[31]) ? rs_abs : bus.rs_val};
            b_d     = {1'b0, (sgn & bus.rt_val[31]) ? rt_abs : bus.rt_val};
            rem_d   = 32'd0;
            qneg_d  = sgn & (bus.rs_val[31] ^ bus.rt_val[31]);
            rneg_d  = sgn & bus.rs_val[31];
            cnt_d   = DIV_LD;
            state_d = DIV;
          end
        end
      end
      MUL: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else if (cnt_q == 5'd0) begin
          {hi_d, lo_d} = mul_res;
          done_d       = 1'b1;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      DIV: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          a_d   = {1'b0, quo_nx};
          rem_d = rem_nx;
          if (cnt_q == 5'd0) begin
            lo_d    = qneg_q ? -quo_nx : quo_nx;
            hi_d    = rneg_q ? -rem_nx : rem_nx;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      a_q     <= 33'd0;
      b_q     <= 33'd0;
      rem_q   <= 32'd0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      acc_q   <= 2'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- HI/LO multiply/divide unit inside the EX stage, directly upstream of MEM.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO issued from EX and runs multi-cycle operations in the background.
- Publishes HI/LO to EX so MFHI/MFLO results enter the EX/MEM register as EXout.
- Raises busy so the controller stalls any HI/LO consumer or new mul/div issue.

Parameters:
- MUL_CYCLES, 4: cycles from multiply accept to HI/LO update; legal range 1..16.
- DIV_CYCLES, 32: radix-2 restoring iterations; fixed at 32, not overridable.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  EX holds a valid mul/div/mt instruction this cycle
- op  in  4  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU, 8 MSUB, 9 MSUBU, others no-op
- rs_val  in  32  forwarded rs operand (dividend / multiplicand / MT source)
- rt_val  in  32  forwarded rt operand (divisor / multiplier)
- flush  in  1  controller EX_FLUSH; aborts the in-flight operation
- busy  out  1  registered; high while state != IDLE
- done  out  1  registered one-cycle pulse, high in the cycle after a mul/div result is written
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Reset (async): state IDLE, counter 0, hi = lo = 0, busy = 0, done = 0, operand registers 0.
- States: IDLE, MUL, DIV.
- Accept:
  - start is accepted only when state is IDLE and flush is low.
  - start while busy is ignored; the controller must hold the instruction.
- MTHI/MTLO:
  - Write hi/lo at the accepting edge.
  - Stay IDLE; no busy, no done.
  - New value is visible on hi/lo in the next cycle.
- MULT/MULTU:
  - At the accepting edge, latch operands: sign-extend to 33 bits for MULT, zero-extend for MULTU.
  - Load counter with MUL_CYCLES-1 and go to MUL.
  - In MUL, decrement each cycle.
  - At the edge where counter == 0, write {hi, lo} = low 64 bits of the 66-bit product, go IDLE, set done.
  - busy is high for exactly MUL_CYCLES cycles.
- DIV/DIVU:
  - At the accepting edge, latch |rs| and |rt| (DIV) or raw values (DIVU), plus result sign flags. Go to DIV with a 32-iteration counter.
  - Each cycle: shift the 33-bit remainder left by one, bring in the next dividend bit, trial-subtract the divisor, set the quotient bit.
  - After the 32nd iteration edge:
    - lo = quotient, negated if sign(rs) != sign(rt) (DIV only).
    - hi = remainder, negated if rs is negative (DIV only).
    - Go IDLE and set done.
  - busy is high for exactly 32 cycles.
- Divide by zero (rt == 0): still takes 32 cycles. Result is lo = 0xFFFFFFFF, hi = rs_val (unsigned quotient/remainder of the algorithm), with sign fixup suppressed.
- Overflow DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0. Wraps, no trap.
- flush:
  - When high in MUL or DIV: next edge → IDLE; hi/lo unchanged; done stays 0.
  - When high in IDLE: any coincident start, including MT, is dropped.
- done: high for one cycle only; low in all other cycles.
- hi/lo change only at:
  - the MT accept edge, or
  - the final mul/div edge (not on flush or abort).
- No partial result is ever visible on hi/lo.

Optional Feature:
- Macro: MULDIV_MADD_EN.
- Defined: ops 6..9 behave like MULT (6, 8) or MULTU (7, 9) with the same MUL_CYCLES latency.
  - The final write is {hi, lo} = {hi, lo} + product (MADD/MADDU) or {hi, lo} − product (MSUB/MSUBU).
  - The accumulator used is the {hi, lo} value at the final edge, modulo 2^64.
- Undefined: ops 6..9 are no-ops. No accept, no busy, hi/lo untouched.

Test Plan:
- MULT rs = 0xFFFFFFFF, rt = 2, MUL_CYCLES = 4 → busy high 4 cycles; hi = 0xFFFFFFFF, lo = 0xFFFFFFFE; done pulses once. MULTU with same operands → hi = 0x00000001, lo = 0xFFFFFFFE.
- DIV rs = 0xFFFFFFF9 (−7), rt = 2 → after 32 busy cycles lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. DIVU rs = 100, rt = 7 → lo = 14, hi = 2.
- DIVU rs = 0x12345678, rt = 0 → 32 cycles, then lo = 0xFFFFFFFF, hi = 0x12345678. DIV 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- MTHI 0xAAAA5555 then DIV started; flush asserted at busy cycle 10 → busy low next cycle, hi = 0xAAAA5555 kept, no done. start asserted while busy → ignored, hi/lo unaffected.
- Reset asserted mid-MUL (cycle 2) → busy, done, hi, lo all 0 immediately (async); a later MTLO 5 → lo = 5.
- MULTI_MADD_EN defined: hi = 0, lo = 0xFFFFFFFF, MADDU 1 × 1 → hi = 1, lo = 0. Undefined: same stimulus → no busy, hi/lo unchanged.
